// File: rtl/decoder_stage.sv
// -----------------------------------------------------------------------------
// decoder_stage
//   Registered instruction decoder. Each rising edge of clk samples the 16-bit
//   instruction word ([15:12] opcode, [11:8] register field, [7:0] immediate)
//   and presents the matching control word one cycle later.
//
// Ports
//   clk            in   1  rising-edge clock for all state
//   rst_n          in   1  synchronous active-low reset (outputs -> NOP)
//   instruction    in  16  instruction word
//   MemoryWrite    out  1  memory store enable
//   WriteRegFrom   out  2  writeback source: 0 memory, 1 ALU, 2 immediate
//   RegToWrite     out  4  destination register index (instruction[11:8])
//   Immediate      out  8  immediate / branch target (instruction[7:0])
//   RegWriteEnSc   out  1  scalar register-file write enable
//   RegWriteEnVec  out  1  vector register-file write enable
//   OverWriteNz    out  1  update N/Z flags
//   PcWriteEn      out  3  PC load enable: bit2 jmp, bit1 je, bit0 jne
//   AluOpCode      out  3  ALU operation
//   IllegalOp      out  1  opcode 0xB/0xE seen (only with DECODER_ILLEGAL_OP_EN)
//
// Build option
//   DECODER_ILLEGAL_OP_EN  adds the registered IllegalOp output.
// -----------------------------------------------------------------------------
module decoder_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instruction,
  output logic        MemoryWrite,
  output logic [1:0]  WriteRegFrom,
  output logic [3:0]  RegToWrite,
  output logic [7:0]  Immediate,
  output logic        RegWriteEnSc,
  output logic        RegWriteEnVec,
  output logic        OverWriteNz,
  output logic [2:0]  PcWriteEn,
`ifdef DECODER_ILLEGAL_OP_EN
  output logic        IllegalOp,
`endif
  output logic [2:0]  AluOpCode
);

  typedef enum logic [3:0] {
    OP_LOSC  = 4'h0,
    OP_XOR   = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_MUL   = 4'h4,
    OP_RSHF  = 4'h5,
    OP_LSHF  = 4'h6,
    OP_INC   = 4'h7,
    OP_JE    = 4'h8,
    OP_JNE   = 4'h9,
    OP_JMP   = 4'hA,
    OP_RSVB  = 4'hB,
    OP_SVPIX = 4'hC,
    OP_LOPIX = 4'hD,
    OP_RSVE  = 4'hE,
    OP_LMEM  = 4'hF
  } opcode_e;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;

  opcode_e opcode;
  assign opcode = opcode_e'(instruction[15:12]);

  // Next-state control word
  logic       mem_write_d;
  logic [1:0] wb_sel_d;
  logic       reg_we_sc_d;
  logic       reg_we_vec_d;
  logic       nz_we_d;
  logic [2:0] pc_we_d;
  logic [2:0] alu_op_d;
  logic       illegal_d;

  // Registered control word
  logic       mem_write_q;
  logic [1:0] wb_sel_q;
  logic [3:0] reg_idx_q;
  logic [7:0] imm_q;
  logic       reg_we_sc_q;
  logic       reg_we_vec_q;
  logic       nz_we_q;
  logic [2:0] pc_we_q;
  logic [2:0] alu_op_q;
  logic       illegal_q;

  always_comb begin
    // Everything defaults to NOP; each opcode only raises what it needs.
    mem_write_d  = 1'b0;
    wb_sel_d     = WB_MEM;
    reg_we_sc_d  = 1'b0;
    reg_we_vec_d = 1'b0;
    nz_we_d      = 1'b0;
    pc_we_d      = 3'b000;
    alu_op_d     = 3'd0;
    illegal_d    = 1'b0;

    case (opcode)
      OP_LOSC: begin
        reg_we_sc_d = 1'b1;
        wb_sel_d    = WB_IMM;
      end
      // Vector ALU ops: the low opcode bits are the ALU operation code.
      OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_RSHF, OP_LSHF: begin
        alu_op_d     = instruction[14:12];
        wb_sel_d     = WB_ALU;
        nz_we_d      = 1'b1;
        reg_we_vec_d = 1'b1;
      end
      // inc shares the ALU path but writes the scalar register file.
      OP_INC: begin
        alu_op_d    = 3'd7;
        wb_sel_d    = WB_ALU;
        nz_we_d     = 1'b1;
        reg_we_sc_d = 1'b1;
      end
      OP_JE:    pc_we_d = 3'b010;
      OP_JNE:   pc_we_d = 3'b001;
      OP_JMP:   pc_we_d = 3'b100;
      OP_SVPIX: mem_write_d = 1'b1;
      OP_LOPIX: begin
        reg_we_vec_d = 1'b1;
        wb_sel_d     = WB_MEM;
      end
      OP_LMEM: begin
        reg_we_sc_d = 1'b1;
        wb_sel_d    = WB_MEM;
      end
      // Reserved opcodes behave as NOP; flagged for the optional output.
      OP_RSVB, OP_RSVE: illegal_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // The instruction sampled on a reset edge is dropped entirely.
      mem_write_q  <= 1'b0;
      wb_sel_q     <= WB_MEM;
      reg_idx_q    <= 4'd0;
      imm_q        <= 8'd0;
      reg_we_sc_q  <= 1'b0;
      reg_we_vec_q <= 1'b0;
      nz_we_q      <= 1'b0;
      pc_we_q      <= 3'b000;
      alu_op_q     <= 3'd0;
      illegal_q    <= 1'b0;
    end else begin
      mem_write_q  <= mem_write_d;
      wb_sel_q     <= wb_sel_d;
      reg_idx_q    <= instruction[11:8];
      imm_q        <= instruction[7:0];
      reg_we_sc_q  <= reg_we_sc_d;
      reg_we_vec_q <= reg_we_vec_d;
      nz_we_q      <= nz_we_d;
      pc_we_q      <= pc_we_d;
      alu_op_q     <= alu_op_d;
      illegal_q    <= illegal_d;
    end
  end

  assign MemoryWrite   = mem_write_q;
  assign WriteRegFrom  = wb_sel_q;
  assign RegToWrite    = reg_idx_q;
  assign Immediate     = imm_q;
  assign RegWriteEnSc  = reg_we_sc_q;
  assign RegWriteEnVec = reg_we_vec_q;
  assign OverWriteNz   = nz_we_q;
  assign PcWriteEn     = pc_we_q;
  assign AluOpCode     = alu_op_q;

`ifdef DECODER_ILLEGAL_OP_EN
  assign IllegalOp = illegal_q;
`else
  // Without the option the flag register has no load and is trimmed away.
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_decoder_stage.sv
module tb_decoder_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] instruction;
  logic        MemoryWrite;
  logic [1:0]  WriteRegFrom;
  logic [3:0]  RegToWrite;
  logic [7:0]  Immediate;
  logic        RegWriteEnSc;
  logic        RegWriteEnVec;
  logic        OverWriteNz;
  logic [2:0]  PcWriteEn;
  logic [2:0]  AluOpCode;
  logic        dut_ill;

  int errors = 0;
  int checks = 0;

  decoder_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .MemoryWrite  (MemoryWrite),
    .WriteRegFrom (WriteRegFrom),
    .RegToWrite   (RegToWrite),
    .Immediate    (Immediate),
    .RegWriteEnSc (RegWriteEnSc),
    .RegWriteEnVec(RegWriteEnVec),
    .OverWriteNz  (OverWriteNz),
    .PcWriteEn    (PcWriteEn),
`ifdef DECODER_ILLEGAL_OP_EN
    .IllegalOp    (dut_ill),
`endif
    .AluOpCode    (AluOpCode)
  );

`ifndef DECODER_ILLEGAL_OP_EN
  assign dut_ill = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {mw, wrf[2], rtw[4], imm[8], sc, vec, nz, pc[3], alu[3], ill}
  function automatic logic [24:0] dut_word();
    return {MemoryWrite, WriteRegFrom, RegToWrite, Immediate, RegWriteEnSc,
            RegWriteEnVec, OverWriteNz, PcWriteEn, AluOpCode, dut_ill};
  endfunction

  // Reference: control word expected after an edge that sampled (ins, rst).
  function automatic logic [24:0] model(input logic [15:0] ins, input logic rst);
    int op;
    logic mw, sc, vec, nz, ill;
    logic [1:0] wrf;
    logic [2:0] pc, alu;
    op  = int'(ins[15:12]);
    mw  = (op == 12);
    sc  = (op == 0) || (op == 7) || (op == 15);
    vec = (op >= 1 && op <= 6) || (op == 13);
    nz  = (op >= 1 && op <= 7);
    alu = (op >= 1 && op <= 7) ? 3'(op) : 3'd0;
    wrf = (op == 0) ? 2'd2 : ((op >= 1 && op <= 7) ? 2'd1 : 2'd0);
    pc  = (op == 8) ? 3'b010 : (op == 9) ? 3'b001 : (op == 10) ? 3'b100 : 3'b000;
`ifdef DECODER_ILLEGAL_OP_EN
    ill = (op == 11) || (op == 14);
`else
    ill = 1'b0;
`endif
    if (!rst) return 25'd0;
    return {mw, wrf, ins[11:8], ins[7:0], sc, vec, nz, pc, alu, ill};
  endfunction

  // Apply one instruction/reset value for a single edge; sample #1 after it.
  task automatic step(input logic [15:0] ins, input logic rst);
    @(negedge clk);
    instruction = ins;
    rst_n       = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string name, input logic [15:0] ins, input logic rst);
    logic [24:0] exp_w;
    logic [24:0] got_w;
    exp_w = model(ins, rst);
    got_w = dut_word();
    checks++;
    if (got_w !== exp_w) begin
      errors++;
      $display("FAIL %s ins=%h rst_n=%0b got=%h exp=%h", name, ins, rst, got_w, exp_w);
    end else begin
      $display("ok   %s ins=%h rst_n=%0b word=%h", name, ins, rst, got_w);
    end
  endtask

  task automatic test_reset();
    step(16'hF510, 1'b0);
    step(16'hF510, 1'b0);
    checks++;
    if (dut_word() !== 25'd0) begin
      errors++;
      $display("FAIL reset_zero got=%h exp=0", dut_word());
    end else $display("ok   reset_zero");
    step(16'hF510, 1'b1);
    checks++;
    if ({RegWriteEnSc, WriteRegFrom, RegToWrite, Immediate} !== {1'b1, 2'd0, 4'd5, 8'd16}) begin
      errors++;
      $display("FAIL reset_release sc=%0b wrf=%0d rtw=%0d imm=%0d exp sc=1 wrf=0 rtw=5 imm=16",
               RegWriteEnSc, WriteRegFrom, RegToWrite, Immediate);
    end else $display("ok   reset_release");
    check_word("reset_release_word", 16'hF510, 1'b1);
  endtask

  task automatic test_directed();
    logic [15:0] vec [0:9];
    vec = '{16'h0612, 16'h3260, 16'hA015, 16'h8010, 16'h9032,
            16'h7E00, 16'hD200, 16'hC300, 16'hB123, 16'hE000};
    for (int i = 0; i < 10; i++) begin
      step(vec[i], 1'b1);
      check_word("directed", vec[i], 1'b1);
    end
    // Hand-derived spot check on the last word (0xE000 is a NOP).
    checks++;
    if ({MemoryWrite, RegWriteEnSc, RegWriteEnVec, OverWriteNz, PcWriteEn} !== 7'd0) begin
      errors++;
      $display("FAIL nop_enables got=%b exp=0000000",
               {MemoryWrite, RegWriteEnSc, RegWriteEnVec, OverWriteNz, PcWriteEn});
    end else $display("ok   nop_enables");
  endtask

  task automatic test_all_opcodes();
    for (int op = 0; op < 16; op++) begin
      logic [15:0] ins;
      ins = {4'(op), 12'($urandom)};
      step(ins, 1'b1);
      check_word("opcode_sweep", ins, 1'b1);
    end
  endtask

  task automatic test_mid_reset();
    step(16'h2345, 1'b1);
    check_word("mid_before", 16'h2345, 1'b1);
    step(16'hC1FF, 1'b0);
    check_word("mid_reset", 16'hC1FF, 1'b0);
    step(16'h7A55, 1'b1);
    check_word("mid_resume", 16'h7A55, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ins;
      logic rst;
      int hot;
      ins = 16'($urandom);
      rst = ($urandom_range(0, 9) != 0);
      step(ins, rst);
      check_word("random", ins, rst);
      hot = int'(RegWriteEnSc) + int'(RegWriteEnVec) + int'(MemoryWrite) +
            int'(PcWriteEn[0]) + int'(PcWriteEn[1]) + int'(PcWriteEn[2]);
      checks++;
      if (hot > 1) begin
        errors++;
        $display("FAIL exclusive_enables ins=%h active=%0d exp<=1", ins, hot);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instruction = 16'h0000;
    test_reset();
    test_directed();
    test_all_opcodes();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
